// File: rtl/exe_pkg.sv
// Shared constants for the EX stage: EXE_CMD encodings, control-word
// bit positions and NZCV status bit positions.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam int unsigned CTRL_W     = 9;
  localparam int unsigned CW_WB_EN   = 8;
  localparam int unsigned CW_MEM_R   = 7;
  localparam int unsigned CW_MEM_W   = 6;
  localparam int unsigned CW_CMD_HI  = 5;
  localparam int unsigned CW_CMD_LO  = 2;
  localparam int unsigned CW_B       = 1;
  localparam int unsigned CW_S       = 0;

  localparam int unsigned ST_N = 3;
  localparam int unsigned ST_Z = 2;
  localparam int unsigned ST_C = 1;
  localparam int unsigned ST_V = 0;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the EX stage. flag_we marks a recognised command
// (N/Z may update); cv_we additionally marks arithmetic commands (C/V may update).
module exe_alu
  import exe_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] res,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic        flag_we,
  output logic        cv_we
);

  logic        is_sub;
  logic        carry_in;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // Shared adder: subtraction is a + ~b + carry, so C comes out as NOT borrow.
  always_comb begin
    is_sub   = (cmd == CMD_SUB) || (cmd == CMD_SBC);
    b_eff    = is_sub ? ~b : b;
    carry_in = 1'b0;
    case (cmd)
      CMD_ADC, CMD_SBC: carry_in = cin;
      CMD_SUB:          carry_in = 1'b1;
      default:          carry_in = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + 33'(carry_in);
  end

  // Result select and flag generation.
  always_comb begin
    res     = '0;
    flag_we = 1'b1;
    cv_we   = 1'b0;
    case (cmd)
      CMD_MOV: res = b;
      CMD_MVN: res = ~b;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        res   = sum[31:0];
        cv_we = 1'b1;
      end
      CMD_AND: res = a & b;
      CMD_ORR: res = a | b;
      CMD_EOR: res = a ^ b;
      default: flag_we = 1'b0;
    endcase
    n = res[31];
    z = (res == 32'd0);
    c = sum[32];
    v = (a[31] == b_eff[31]) && (sum[31] != a[31]);
  end

endmodule

// File: rtl/exe_stage_ctrl.sv
// EX stage: ID/EX pipeline register, ALU dispatch, NZCV status register
// and EX/MEM output register.
// Optional: define EXE_PERF_CNT_EN to add instr_cnt_o / bubble_cnt_o counters.
module exe_stage_ctrl
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned IMM_W      = 24,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_W-1:0]     ctrl_word,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     val_rn,
  input  logic [DATA_W-1:0]     val2,
  input  logic [DATA_W-1:0]     st_val_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [IMM_W-1:0]      imm24_in,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  valid_o,
  output logic                  wb_en_o,
  output logic                  mem_r_en_o,
  output logic                  mem_w_en_o,
  output logic [DATA_W-1:0]     alu_res_o,
  output logic [DATA_W-1:0]     st_val_o,
  output logic [REG_ADDR_W-1:0] dest_o,
  output logic                  branch_taken_o,
  output logic [DATA_W-1:0]     branch_addr_o,
  output logic [3:0]            status_o
`ifdef EXE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      instr_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
`endif
);

  localparam int unsigned SEXT_W = DATA_W - IMM_W - 2;

  logic                  ie_valid;
  logic [CTRL_W-1:0]     ie_ctrl;
  logic [DATA_W-1:0]     ie_rn;
  logic [DATA_W-1:0]     ie_val2;
  logic [DATA_W-1:0]     ie_st;
  logic [REG_ADDR_W-1:0] ie_dest;
  logic [DATA_W-1:0]     ie_pc;
  logic [IMM_W-1:0]      ie_imm;

  logic [DATA_W-1:0]     alu_res;
  logic                  alu_n, alu_z, alu_c, alu_v;
  logic                  alu_flag_we, alu_cv_we;
  logic                  exec_c;
  logic                  is_branch_c;
  logic [DATA_W-1:0]     br_off_c;

  // ID/EX register: flush beats freeze, freeze holds, otherwise load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_valid <= 1'b0;
      ie_ctrl  <= '0;
      ie_rn    <= '0;
      ie_val2  <= '0;
      ie_st    <= '0;
      ie_dest  <= '0;
      ie_pc    <= '0;
      ie_imm   <= '0;
    end else if (flush) begin
      ie_valid <= 1'b0;
    end else if (!freeze) begin
      ie_valid <= valid_in;
      ie_ctrl  <= ctrl_word;
      ie_rn    <= val_rn;
      ie_val2  <= val2;
      ie_st    <= st_val_in;
      ie_dest  <= dest_in;
      ie_pc    <= pc_in;
      ie_imm   <= imm24_in;
    end
  end

  exe_alu u_alu (
    .cmd     (ie_ctrl[CW_CMD_HI:CW_CMD_LO]),
    .a       (ie_rn),
    .b       (ie_val2),
    .cin     (status_o[ST_C]),
    .res     (alu_res),
    .n       (alu_n),
    .z       (alu_z),
    .c       (alu_c),
    .v       (alu_v),
    .flag_we (alu_flag_we),
    .cv_we   (alu_cv_we)
  );

  // An instruction executes only on the edge where it is valid and not frozen.
  always_comb begin
    exec_c      = ie_valid && !freeze;
    is_branch_c = ie_ctrl[CW_B];
    br_off_c    = {{SEXT_W{ie_imm[IMM_W-1]}}, ie_imm, 2'b00};
  end

  // EX/MEM register: bubbles clear only the flags; data fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o        <= 1'b0;
      wb_en_o        <= 1'b0;
      mem_r_en_o     <= 1'b0;
      mem_w_en_o     <= 1'b0;
      branch_taken_o <= 1'b0;
      alu_res_o      <= '0;
      st_val_o       <= '0;
      dest_o         <= '0;
      branch_addr_o  <= '0;
    end else begin
      valid_o        <= exec_c;
      wb_en_o        <= exec_c && !is_branch_c && ie_ctrl[CW_WB_EN];
      mem_r_en_o     <= exec_c && !is_branch_c && ie_ctrl[CW_MEM_R];
      mem_w_en_o     <= exec_c && !is_branch_c && ie_ctrl[CW_MEM_W];
      branch_taken_o <= exec_c && is_branch_c;
      if (exec_c) begin
        alu_res_o     <= alu_res;
        st_val_o      <= ie_st;
        dest_o        <= ie_dest;
        branch_addr_o <= ie_pc + br_off_c;
      end
    end
  end

  // NZCV commit; logic/move ops leave C and V untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_o <= '0;
    end else if (exec_c && ie_ctrl[CW_S] && !is_branch_c && alu_flag_we) begin
      status_o[ST_N] <= alu_n;
      status_o[ST_Z] <= alu_z;
      if (alu_cv_we) begin
        status_o[ST_C] <= alu_c;
        status_o[ST_V] <= alu_v;
      end
    end
  end

`ifdef EXE_PERF_CNT_EN
  // Each edge is exactly one EX/MEM write: either an instruction or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (exec_c) begin
      instr_cnt_o  <= instr_cnt_o + CNT_W'(1);
    end else begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/exe_stage_ctrl.md
Name: exe_stage_ctrl

Overview:
Consumer of the 9-bit control word produced by the ID-stage control unit. Holds the ID/EX pipeline register and decodes EXE_CMD into ALU operations. Owns the NZCV status register and registers results, memory enables and branch outcome into the EX/MEM boundary for the MEM stage.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_ADDR_W, 4, destination register index width.
IMM_W, 24, branch immediate width.
CNT_W, 32, performance counter width; used only with EXE_PERF_CNT_EN.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
ctrl_word  in  9  {WB_EN[8], MEM_R_EN[7], MEM_W_EN[6], EXE_CMD[5:2], B[1], S[0]}
valid_in  in  1  ctrl_word and operands carry a real instruction
val_rn  in  DATA_W  first operand
val2  in  DATA_W  second operand, already shifted or immediate
st_val_in  in  DATA_W  store data (Rm/Rd value)
dest_in  in  REG_ADDR_W  destination register index
pc_in  in  DATA_W  PC+4 of the instruction
imm24_in  in  IMM_W  signed branch offset in words
freeze  in  1  hold ID/EX contents
flush  in  1  turn the ID/EX entry into a bubble
valid_o, wb_en_o, mem_r_en_o, mem_w_en_o  out  1 each  EX/MEM stage flags
alu_res_o  out  DATA_W  ALU result; address for LDR/STR
st_val_o  out  DATA_W  store data
dest_o  out  REG_ADDR_W  destination index
branch_taken_o  out  1  one-cycle pulse
branch_addr_o  out  DATA_W  pc + (sext(imm24) << 2)
status_o  out  4  committed {N,Z,C,V}

Behaviour:
- Reset (rst=0, asynchronous): all ID/EX and EX/MEM state, all outputs, and status are 0.
- Latency: an instruction presented at edge k enters ID/EX. Its results appear on the outputs after edge k+1. Status commits at edge k+1.
- ID/EX update at each edge, in priority order:
  - flush=1: valid bit cleared; other fields don't-care.
  - else freeze=1: ID/EX holds its contents.
  - else: loads all inputs, with valid = valid_in.
- EX/MEM update at each edge: if ID/EX is invalid or freeze=1, a bubble is written (valid_o, wb/mem enables, branch_taken_o all 0). Otherwise the computed values are written. A frozen instruction therefore executes exactly once.
- EXE_CMD decode (A=val_rn, B=val2, Cin=status C):
  - 0001 MOV = B; 1001 MVN = ~B
  - 0010 ADD = A+B; 0011 ADC = A+B+Cin
  - 0100 SUB = A-B; 0101 SBC = A-B-!Cin
  - 0110 AND; 0111 ORR; 1000 EOR
  - any other code: result 0, status never updated.
- Flags:
  - N = res[31]; Z = (res == 0).
  - ADD/ADC: C is bit 32 of the 33-bit sum.
  - SUB/SBC: C = NOT borrow.
  - V is set on signed overflow of the add/sub.
  - Logic ops and MOV/MVN: C and V unchanged.
- Status commit: S=1 and the instruction is valid and not frozen. A back-to-back ADC after ADDS sees the new C with no stall.
- B=1 and valid: branch_taken_o=1 and branch_addr_o is computed. wb_en_o and mem enables are forced to 0, the ALU result is ignored, and status is unchanged. Issuing the upstream flush is the hazard unit's job, not this block's.
- Memory ops arrive as EXE_CMD 0010: alu_res_o = val_rn + val2. st_val_o is passed through.
- Arithmetic wraps modulo 2^32.

Optional Feature:
EXE_PERF_CNT_EN.
- Defined: adds ports instr_cnt_o and bubble_cnt_o (each CNT_W, reset 0).
  - instr_cnt_o increments on every valid EX/MEM write.
  - bubble_cnt_o increments on every bubble write.
  - Both wrap to 0 at 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package exe_pkg:
  - EXE_CMD localparams (MOV 0001 ... EOR 1000).
  - ctrl_word bit-index constants.
  - Status bit indices N=3, Z=2, C=1, V=0.
- Sub-module exe_alu: purely combinational (cmd, A, B, Cin) -> (res, N, Z, C, V, flag_we). The top holds the registers and the status register.

Test Plan:
- ADDS, A=0xFFFFFFFF, B=1, ctrl=0x109 -> alu_res_o=0 one cycle later; status=0110 (Z,C).
- ADC right after it, A=2, B=3 -> alu_res_o=6 (Cin=1 from prior ADDS).
- SUBS, A=0x80000000, B=1 -> res=0x7FFFFFFF; status V=1, C=1, N=0.
- Branch, B=1, pc_in=0x100, imm24=0xFFFFFE -> branch_taken_o=1 for exactly 1 cycle; addr=0xF8; wb_en_o=0; status unchanged.
- MOV held by freeze=1 for 3 cycles -> valid_o=0 for those 3 cycles, then exactly one valid output.
  - flush+freeze together -> bubble; the held instruction is discarded.
- Assert rst mid-stream with valid instructions in flight -> all outputs and status go 0 immediately.
  - Invalid EXE_CMD 1010 with S=1 -> res=0, status unchanged.
